// File: rtl/wb_pkg.sv
// Shared definitions for the ALU writeback stage.
//   - Opcode encodings produced by the master ALU (1100..1111 belong to
//     the memory unit and never write here).
//   - Bit positions inside the packed {N,Z,C,V} flag nibble.
//   - Decoders that turn an opcode into register / flag write intent.
package wb_pkg;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_AND      = 4'b0010;
  localparam logic [3:0] OP_OR       = 4'b0011;
  localparam logic [3:0] OP_XOR      = 4'b0100;
  localparam logic [3:0] OP_SHF      = 4'b0101;
  localparam logic [3:0] OP_MOV      = 4'b0110;
  localparam logic [3:0] OP_MOVN     = 4'b0111;
  localparam logic [3:0] OP_ADC      = 4'b1000;
  localparam logic [3:0] OP_SBC      = 4'b1001;
  localparam logic [3:0] OP_RSB      = 4'b1010;
  localparam logic [3:0] OP_CMP      = 4'b1011;
  localparam logic [3:0] OP_MEM_BASE = 4'b1100;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Everything up to RSB produces a register result; CMP and memory ops do not.
  function automatic logic is_reg_write(input logic [3:0] op);
    return (op <= OP_RSB);
  endfunction

  // MOV/MOVN leave flags alone; CMP updates only flags; memory ops neither.
  function automatic logic is_flag_write(input logic [3:0] op);
    return (op <= OP_SHF) || ((op >= OP_ADC) && (op <= OP_CMP));
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// Register file for the writeback stage.
//   clk, reset        : clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata  : single synchronous write port
//   raddr1/rdata1,
//   raddr2/rdata2     : two asynchronous read ports (old value on same-cycle write)
module wb_regfile #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one pipeline register between the combinational ALU
// and the architectural register file / flag register.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : ALU result handshake (in_ready = ~hold)
//   in_opcode, in_exec    : instruction opcode, condition-passed
//   in_rd, in_result,
//   in_new_flag           : destination, result, {N,Z,C,V}
//   hold, flush           : downstream stall, kill pending + incoming entry
//   rs1/rs2_addr/_data    : operand read ports feeding the ALU
//   flag_out              : flags feeding the ALU
//   commit_pulse          : one cycle high per committed (or bubble) entry
// Build option: define WB_BYPASS_EN to forward the pending entry's result
// and flags onto the read ports.
module alu_writeback
  import wb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_opcode,
  input  logic                        in_exec,
  input  logic [$clog2(NUM_REGS)-1:0] in_rd,
  input  logic [DATA_W-1:0]           in_result,
  input  logic [3:0]                  in_new_flag,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
  input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
  output logic [DATA_W-1:0]           rs1_data,
  output logic [DATA_W-1:0]           rs2_data,
  output logic [3:0]                  flag_out,
  output logic                        commit_pulse
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic              p_valid;
  logic              p_reg_we;
  logic              p_flag_we;
  logic [AW-1:0]     p_rd;
  logic [DATA_W-1:0] p_result;
  logic [3:0]        p_new_flag;
  logic [3:0]        flags;

  logic              accept;
  logic              commit;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  assign in_ready = ~hold;
  assign accept   = in_valid & ~hold & ~flush;
  assign commit   = p_valid  & ~hold & ~flush;

  // Write intent is decoded at accept time so the commit edge only needs
  // the two stored enables; opcode and exec are not kept past this point.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid      <= 1'b0;
      p_reg_we     <= 1'b0;
      p_flag_we    <= 1'b0;
      p_rd         <= '0;
      p_result     <= '0;
      p_new_flag   <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (flush) begin
        p_valid <= 1'b0;
      end else if (!hold) begin
        p_valid <= in_valid;
        if (in_valid) begin
          p_reg_we   <= in_exec & is_reg_write(in_opcode);
          p_flag_we  <= in_exec & is_flag_write(in_opcode);
          p_rd       <= in_rd;
          p_result   <= in_result;
          p_new_flag <= in_new_flag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (commit && p_flag_we) begin
      flags <= p_new_flag;
    end
  end

  wb_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (commit & p_reg_we),
    .waddr  (p_rd),
    .wdata  (p_result),
    .raddr1 (rs1_addr),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2_addr),
    .rdata2 (rf_rdata2)
  );

`ifdef WB_BYPASS_EN
  // Forwarding is keyed on the pending entry alone, so it also applies
  // while hold is asserted.
  always_comb begin
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    flag_out = flags;
    if (p_valid && p_reg_we && (p_rd == rs1_addr)) rs1_data = p_result;
    if (p_valid && p_reg_we && (p_rd == rs2_addr)) rs2_data = p_result;
    if (p_valid && p_flag_we)                      flag_out = p_new_flag;
  end
`else
  assign rs1_data = rf_rdata1;
  assign rs2_data = rf_rdata2;
  assign flag_out = flags;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic        in_exec;
  logic [3:0]  in_rd;
  logic [31:0] in_result;
  logic [3:0]  in_new_flag;
  logic        hold;
  logic        flush;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [3:0]  flag_out;
  logic        commit_pulse;

  always #5 clk = ~clk;

  alu_writeback #(.NUM_REGS(16), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_exec      (in_exec),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .in_new_flag  (in_new_flag),
    .hold         (hold),
    .flush        (flush),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flag_out     (flag_out),
    .commit_pulse (commit_pulse)
  );

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [31:0] val;
    logic [3:0]  flags;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every commit pulse pops one expected entry and checks the
  // destination register (through read port 2) and the flags.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (commit_pulse === 1'b1) begin
        pulses++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got commit_pulse=1 expected 0 at %0t", $time);
        end else begin
          e = q.pop_front();
          rs2_addr = e.rd;
          #1;
          check({e.name, "_reg"}, rs2_data, e.val);
          check({e.name, "_flag"}, {28'd0, flag_out}, {28'd0, e.flags});
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic ex, input logic [3:0] rd,
                       input logic [31:0] res, input logic [3:0] nf);
    in_valid = 1'b1; in_opcode = op; in_exec = ex; in_rd = rd;
    in_result = res; in_new_flag = nf;
  endtask

  // Present one instruction for exactly one edge (hold/flush low).
  task automatic issue(input logic [3:0] op, input logic ex, input logic [3:0] rd,
                       input logic [31:0] res, input logic [3:0] nf);
    drive(op, ex, rd, res, nf);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input string name, input logic [3:0] rd,
                      input logic [31:0] val, input logic [3:0] fl);
    exp_t e;
    e.name = name; e.rd = rd; e.val = val; e.flags = fl;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_exec = 1'b0; in_rd = '0;
    in_result = '0; in_new_flag = '0; hold = 1'b0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_pulse", {31'd0, commit_pulse}, 32'd0);
    check("rst_flags", {28'd0, flag_out}, 32'd0);
    for (int i = 0; i < 16; i += 5) begin
      rs1_addr = 4'(i);
      #1 check("rst_reg", rs1_data, 32'd0);
    end

    // ADD rd3 = 5
    push("add_r3", 4'd3, 32'h0000_0005, 4'b0000);
    issue(OP_ADD, 1'b1, 4'd3, 32'h0000_0005, 4'b0000);
    idle(3);

    // Pending ADD rd4 = 0x10 observed on read port 1
    push("add_r4", 4'd4, 32'h0000_0010, 4'b0000);
    issue(OP_ADD, 1'b1, 4'd4, 32'h0000_0010, 4'b0000);
    rs1_addr = 4'd4;
    #1;
`ifdef WB_BYPASS_EN
    check("pend_rs1_bypass", rs1_data, 32'h0000_0010);
`else
    check("pend_rs1_old", rs1_data, 32'h0000_0000);
`endif
    idle(1);
    check("post_rs1", rs1_data, 32'h0000_0010);
    idle(2);

    // CMP: flags only, rd5 untouched
    push("cmp", 4'd5, 32'h0000_0000, 4'b0100);
    issue(OP_CMP, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'b0100);
    idle(3);

    // MOV rd7: register only, flags keep 0100
    push("mov", 4'd7, 32'hFFFF_0000, 4'b0100);
    issue(OP_MOV, 1'b1, 4'd7, 32'hFFFF_0000, 4'b1111);
    idle(3);

    // SUB rd2 pending under a 3-cycle hold; a competing input is ignored
    push("sub_hold", 4'd2, 32'h0000_1234, 4'b1000);
    issue(OP_SUB, 1'b1, 4'd2, 32'h0000_1234, 4'b1000);
    hold = 1'b1;
    drive(OP_ADD, 1'b1, 4'd2, 32'h0000_9999, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      #1 check("hold_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("hold_no_pulse", {31'd0, commit_pulse}, 32'd0);
    end
    hold = 1'b0; in_valid = 1'b0;
    idle(4);

    // Flush kills pending ADD rd8 and same-cycle XOR rd9
    issue(OP_ADD, 1'b1, 4'd8, 32'h0000_0055, 4'b0010);
    flush = 1'b1;
    drive(OP_XOR, 1'b1, 4'd9, 32'h0000_0066, 4'b0001);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_no_pulse0", {31'd0, commit_pulse}, 32'd0);
    idle(1);
    check("flush_no_pulse1", {31'd0, commit_pulse}, 32'd0);
    rs1_addr = 4'd8; #1 check("flush_r8", rs1_data, 32'd0);
    rs1_addr = 4'd9; #1 check("flush_r9", rs1_data, 32'd0);
    check("flush_flags", {28'd0, flag_out}, {28'd0, 4'b1000});
    idle(2);

    // Back-to-back: ADD, MOV, non-executed ADD, memory opcode bubble
    push("b2b_add", 4'd10, 32'h0000_0001, 4'b0010);
    push("b2b_mov", 4'd11, 32'h0000_0002, 4'b0010);
    push("b2b_noexec", 4'd12, 32'h0000_0000, 4'b0010);
    push("b2b_mem", 4'd13, 32'h0000_0000, 4'b0010);
    issue(OP_ADD, 1'b1, 4'd10, 32'h0000_0001, 4'b0010);
    issue(OP_MOV, 1'b1, 4'd11, 32'h0000_0002, 4'b1111);
    issue(OP_ADD, 1'b0, 4'd12, 32'h0000_0077, 4'b1111);
    issue(OP_MEM_BASE, 1'b1, 4'd13, 32'h0000_0088, 4'b1111);
    idle(4);

    // Pending entry discarded by reset
    issue(OP_ADD, 1'b1, 4'd14, 32'h0000_00AA, 4'b0001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_pend_pulse", {31'd0, commit_pulse}, 32'd0);
    idle(2);
    rs1_addr = 4'd14; #1 check("rst_pend_r14", rs1_data, 32'd0);
    check("rst_pend_flags", {28'd0, flag_out}, 32'd0);

    check("queue_empty", q.size(), 32'd0);
    check("pulse_count", pulses, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
